// File: rtl/hdb3_ami_decode.sv
`default_nettype none
// ============================================================================
//  Module   : hdb3_ami_decode
//  Purpose  : Final stage of the HDB3 receive path. Takes the signed-mark
//             symbol stream left after B/V removal and does four things:
//               - recovers the NRZ bit
//               - flags residual bipolar violations and illegal symbols
//               - declares loss of signal after a long run of non-marks
//               - keeps a saturating error counter for management
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LOS_ZEROS      consecutive non-marks that declare LOS (4..255)
//    CNT_W          width of the error counter
//  Ports
//    clk            line-rate clock, one symbol per cycle
//    rst_n          synchronous active-low reset
//    remove_bv_code symbol: 01 = +1, 11 = -1, 00 = zero, 10 = illegal
//    clr_cnt        synchronous clear of err_cnt
//    data_out       recovered binary bit (1-cycle latency)
//    code_err       one-cycle pulse on a bipolar violation
//    sym_err        one-cycle pulse on an illegal symbol
//    los            loss-of-signal level flag
//    err_cnt        saturating count of code_err + sym_err events
// ============================================================================
module hdb3_ami_decode #(
  parameter int LOS_ZEROS = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       remove_bv_code,
  input  logic             clr_cnt,
  output logic             data_out,
  output logic             code_err,
  output logic             sym_err,
  output logic             los,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0]       c_los_zeros = 8'(LOS_ZEROS);
  localparam logic [7:0]       c_run_max   = 8'hFF;
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  // Line-state registers
  logic             r_last_pol;   // 0 = last mark was +1, 1 = last mark was -1
  logic             r_pol_valid;
  logic [7:0]       r_zero_run;
  logic             r_los;
  logic [CNT_W-1:0] r_err_cnt;

  // Output registers
  logic             r_data_out;
  logic             r_code_err;
  logic             r_sym_err;

  // Symbol classification. Bit 0 set means a mark; bit 1 then carries the
  // polarity, so the polarity bit can be stored directly as last_pol.
  logic             w_is_mark;
  logic             w_mark_pol;
  logic             w_is_illegal;
  logic             w_code_err;
  logic             w_zero_run_inc;
  logic [7:0]       w_zero_run_next;
  logic             w_los_set;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_is_mark    = remove_bv_code[0];
  assign w_mark_pol   = remove_bv_code[1];
  assign w_is_illegal = (remove_bv_code == 2'b10);

  // Upstream has already removed legitimate B/V substitutions, so any two
  // consecutive marks of the same polarity are a genuine line error.
  assign w_code_err = w_is_mark & r_pol_valid & (w_mark_pol == r_last_pol);

  // Zero-run counter saturates so a dead line never wraps back below the
  // LOS threshold.
  assign w_zero_run_inc  = (r_zero_run != c_run_max);
  assign w_zero_run_next = w_zero_run_inc ? (r_zero_run + 8'd1) : r_zero_run;
  assign w_los_set       = ~w_is_mark & (w_zero_run_next == c_los_zeros);

  // Clear first, then count this cycle's error, so a clear coinciding with
  // an error leaves the counter at 1.
  assign w_cnt_base = clr_cnt ? '0 : r_err_cnt;
  assign w_cnt_next = ((w_code_err | w_is_illegal) && (w_cnt_base != c_cnt_max))
                      ? (w_cnt_base + c_cnt_one) : w_cnt_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_pol  <= 1'b0;
      r_pol_valid <= 1'b0;
      r_zero_run  <= 8'd0;
      r_los       <= 1'b0;
      r_err_cnt   <= '0;
      r_data_out  <= 1'b0;
      r_code_err  <= 1'b0;
      r_sym_err   <= 1'b0;
    end else begin
      r_data_out <= w_is_mark;
      r_code_err <= w_code_err;
      r_sym_err  <= w_is_illegal;
      r_err_cnt  <= w_cnt_next;

      if (w_is_mark) begin
        // A violating mark still becomes the new polarity reference.
        r_last_pol  <= w_mark_pol;
        r_pol_valid <= 1'b1;
        r_zero_run  <= 8'd0;
        r_los       <= 1'b0;
      end else begin
        r_zero_run <= w_zero_run_next;
        if (w_los_set) begin
          // After LOS the polarity history is stale; the first mark of the
          // recovered line must not be judged against it.
          r_los       <= 1'b1;
          r_pol_valid <= 1'b0;
        end
      end
    end
  end

  assign data_out = r_data_out;
  assign code_err = r_code_err;
  assign sym_err  = r_sym_err;
  assign los      = r_los;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hdb3_ami_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdb3_ami_decode
//  Purpose  : Self-checking bench for hdb3_ami_decode. Directed scenarios
//             against fixed expected values, plus a randomized stream
//             compared against an integer-level line model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hdb3_ami_decode;

  localparam int LOS_ZEROS = 32;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [1:0]       remove_bv_code;
  logic             clr_cnt;
  logic             data_out;
  logic             code_err;
  logic             sym_err;
  logic             los;
  logic [CNT_W-1:0] err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state (plain integers: polarity +1/-1, 0 = unknown)
  int m_pol;
  int m_zeros;
  int m_cnt;
  bit m_data, m_cerr, m_serr, m_los;

  hdb3_ami_decode #(.LOS_ZEROS(LOS_ZEROS), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .remove_bv_code (remove_bv_code),
    .clr_cnt        (clr_cnt),
    .data_out       (data_out),
    .code_err       (code_err),
    .sym_err        (sym_err),
    .los            (los),
    .err_cnt        (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one symbol for one clock, sample #1 after the edge, and advance
  // the reference model by the same symbol.
  task automatic step(input logic [1:0] code, input bit clr, input bit rst);
    bit is_mark;
    int pol;
    int cnt;
    rst_n          = ~rst;
    remove_bv_code = code;
    clr_cnt        = clr;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pol = 0; m_zeros = 0; m_cnt = 0;
      m_data = 0; m_cerr = 0; m_serr = 0; m_los = 0;
    end else begin
      is_mark = (code == 2'b01) || (code == 2'b11);
      pol     = (code == 2'b01) ? 1 : -1;
      m_data  = is_mark;
      m_cerr  = is_mark && (m_pol != 0) && (pol == m_pol);
      m_serr  = (code == 2'b10);
      if (is_mark) begin
        m_pol = pol; m_zeros = 0; m_los = 0;
      end else begin
        m_zeros = (m_zeros < 255) ? m_zeros + 1 : 255;
        if (m_zeros == LOS_ZEROS) begin
          m_los = 1; m_pol = 0;
        end
      end
      cnt = clr ? 0 : m_cnt;
      if (m_cerr || m_serr) cnt = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
      m_cnt = cnt;
    end
  endtask

  task automatic test_reset();
    step(2'b01, 1'b1, 1'b1);
    tests_run++;
    if ({data_out, code_err, sym_err, los} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {data_out, code_err, sym_err, los});
    end
    tests_run++;
    if (err_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_alternating();
    logic [1:0] seq [6] = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11};
    bit         exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(seq[i], 1'b0, 1'b0);
      tests_run++;
      if ({data_out, code_err} !== {exp[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL alt_sym%0d: got data/cerr %b%b expected %b0", i, data_out, code_err, exp[i]);
      end
    end
    tests_run++;
    if (err_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL alt_cnt: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_violation();
    logic [1:0] seq [4] = '{2'b01, 2'b00, 2'b01, 2'b11};
    bit         exp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(seq[i], 1'b0, 1'b0);
      tests_run++;
      if (code_err !== exp[i]) begin
        tests_failed++;
        $display("FAIL viol_sym%0d: got code_err %b expected %b", i, code_err, exp[i]);
      end
    end
    tests_run++;
    if (err_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL viol_cnt: got %0d expected 1", err_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] seq [3] = '{2'b01, 2'b10, 2'b11};
    logic [2:0] exp [3] = '{3'b100, 3'b001, 3'b100}; // {data, cerr, serr}
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(seq[i], 1'b0, 1'b0);
      tests_run++;
      if ({data_out, code_err, sym_err} !== exp[i]) begin
        tests_failed++;
        $display("FAIL illegal_sym%0d: got %b expected %b", i, {data_out, code_err, sym_err}, exp[i]);
      end
    end
    tests_run++;
    if (err_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL illegal_cnt: got %0d expected 1", err_cnt);
    end
  endtask

  task automatic test_los();
    int early = 0;
    step(2'b00, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b0);
    for (int i = 1; i < LOS_ZEROS; i++) begin
      step(2'b00, 1'b0, 1'b0);
      if (los !== 1'b0) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL los_early: got %0d cycles with los=1 expected 0", early);
    end
    step(2'b00, 1'b0, 1'b0);
    tests_run++;
    if ({los, data_out} !== 2'b10) begin
      tests_failed++;
      $display("FAIL los_rise: got los/data %b expected 10", {los, data_out});
    end
    step(2'b01, 1'b0, 1'b0);
    tests_run++;
    if ({los, data_out, code_err} !== 3'b010) begin
      tests_failed++;
      $display("FAIL los_fall: got los/data/cerr %b expected 010", {los, data_out, code_err});
    end
  endtask

  task automatic test_saturation();
    step(2'b00, 1'b0, 1'b1);
    step(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(2'b01, 1'b0, 1'b0);
    tests_run++;
    if (err_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d expected 15", err_cnt);
    end
    step(2'b01, 1'b1, 1'b0);
    tests_run++;
    if ({code_err, err_cnt} !== {1'b1, 4'd1}) begin
      tests_failed++;
      $display("FAIL sat_clr_err: got cerr=%b cnt=%0d expected cerr=1 cnt=1", code_err, err_cnt);
    end
    step(2'b00, 1'b1, 1'b0);
    tests_run++;
    if (err_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL sat_clr: got %0d expected 0", err_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < LOS_ZEROS; i++) step(2'b00, 1'b0, 1'b0);
    tests_run++;
    if ({los, err_cnt} !== {1'b1, 4'd5}) begin
      tests_failed++;
      $display("FAIL mid_pre: got los=%b cnt=%0d expected los=1 cnt=5", los, err_cnt);
    end
    step(2'b01, 1'b0, 1'b1);
    tests_run++;
    if ({data_out, code_err, sym_err, los, err_cnt} !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got %b expected 00000000", {data_out, code_err, sym_err, los, err_cnt});
    end
    step(2'b01, 1'b0, 1'b0);
    tests_run++;
    if (code_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_first: got code_err %b expected 0", code_err);
    end
    step(2'b01, 1'b0, 1'b0);
    tests_run++;
    if ({code_err, err_cnt} !== {1'b1, 4'd1}) begin
      tests_failed++;
      $display("FAIL mid_second: got cerr=%b cnt=%0d expected cerr=1 cnt=1", code_err, err_cnt);
    end
  endtask

  task automatic test_random();
    int         burst = 0;
    logic [1:0] code;
    bit         clr, rst;
    logic [7:0] exp;
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      if (burst > 0) begin
        code  = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
        burst = burst - 1;
      end else begin
        if ($urandom_range(0, 24) == 0) burst = $urandom_range(25, 45);
        code = 2'($urandom_range(0, 3));
      end
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(code, clr, rst);
      exp = {m_data, m_cerr, m_serr, m_los, 4'(m_cnt)};
      tests_run++;
      if ({data_out, code_err, sym_err, los, err_cnt} !== exp) begin
        tests_failed++;
        $display("FAIL random_step%0d: got %b expected %b (code=%b clr=%b rst=%b)",
                 i, {data_out, code_err, sym_err, los, err_cnt}, exp, code, clr, rst);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    remove_bv_code = 2'b00;
    clr_cnt        = 1'b0;
    @(negedge clk);
    test_reset();
    test_alternating();
    test_violation();
    test_illegal();
    test_los();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdb3_ami_decode.md
# hdb3_ami_decode

Final stage of the HDB3 receive path, directly downstream of the B/V-removal stage. Consumes the 2-bit signed-mark stream that stage produces, recovers the NRZ binary bit, and monitors line quality. Flags residual bipolar violations and illegal symbols, detects loss of signal (LOS) from long zero runs, and keeps a saturating error counter for the management interface.

## Interface
- LOS_ZEROS, 32: consecutive non-mark symbols that declare LOS (legal range 4..255).
- CNT_W, 16: width of the error counter.

- clk  input  1  line-rate clock; one symbol per cycle.
- rst_n  input  1  synchronous, active-low reset.
- remove_bv_code  input  2  symbol from the B/V-removal stage:
  - 2'b01 = +1 mark
  - 2'b11 = -1 mark
  - 2'b00 = zero
  - 2'b10 = illegal
- clr_cnt  input  1  synchronous clear of err_cnt.
- data_out  output  1  recovered binary bit.
- code_err  output  1  one-cycle pulse on a bipolar violation.
- sym_err  output  1  one-cycle pulse on an illegal symbol.
- los  output  1  loss-of-signal level flag.
- err_cnt  output  CNT_W  saturating count of code_err plus sym_err events.

## Operation
- **Mark definition.** A mark is an input of 01 or 11. Every other input is a non-mark.
- **State held:**
  - last_pol: polarity of the most recent mark.
  - pol_valid: last_pol is meaningful.
  - zero_run: 8-bit saturating count of consecutive non-marks.
  - los register.
  - err_cnt register.
- **Decode.**
  - A mark produces data_out = 1.
  - 00 and 10 produce data_out = 0.
- **Violation check.** A mark whose polarity equals last_pol while pol_valid = 1 produces code_err = 1.
  - B/V substitutions are already stripped upstream, so any same-polarity pair is an error.
  - A violating mark still updates last_pol. It also still outputs data_out = 1.
- **Polarity tracking.**
  - Every mark sets last_pol to its own polarity and sets pol_valid = 1.
  - pol_valid is cleared by reset and whenever los asserts.
  - Consequence: the first mark after reset, or after LOS, is never flagged.
- **Illegal symbol.** Input 10 produces sym_err = 1.
  - last_pol is not changed.
  - The symbol counts as a non-mark for zero_run.
- **LOS.**
  - A non-mark increments zero_run, saturating at 255.
  - A mark clears zero_run to 0.
  - los sets on the cycle when zero_run reaches LOS_ZEROS.
  - los clears on the first mark. That mark's data_out = 1 appears in the same cycle that los falls.
- **Error counter.**
  - err_cnt increments by 1 on every cycle where code_err or sym_err is asserted. The two are mutually exclusive.
  - err_cnt saturates at 2^CNT_W - 1 and does not wrap.
  - clr_cnt = 1 loads 0. If clr_cnt coincides with an error, err_cnt becomes 1: the clear applies, then that cycle's error is counted.
- **Reset.** rst_n = 0 at a clock edge forces:
  - outputs: data_out = 0, code_err = 0, sym_err = 0, los = 0, err_cnt = 0
  - internal state: zero_run = 0, pol_valid = 0, last_pol = 0
  - This applies mid-stream too; no partial state survives.

## Timing
- Latency: 1 cycle.
  - Symbol sampled at edge n drives data_out, code_err and sym_err after edge n.
  - Those outputs are valid throughout cycle n+1.
- code_err and sym_err are registered and aligned with the data_out bit they describe.
- err_cnt updates on the same edge as the corresponding pulse, so it is visible in the same cycle as the pulse.
- los asserts on the edge that registers the LOS_ZEROS-th consecutive non-mark, aligned with that symbol's data_out = 0.
- los deasserts on the edge that registers the next mark.
- No back-pressure: one symbol per clock is consumed unconditionally.

## Test plan
- **Alternating marks.** Apply after reset: 01, 00, 11, 01, 00, 11.
  - data_out = 1,0,1,1,0,1 with 1-cycle latency.
  - code_err never asserts; err_cnt = 0.
- **Violation.** Apply 01, 00, 01.
  - code_err pulses exactly once, aligned with the third data_out.
  - err_cnt = 1.
  - A following 11 raises no error.
- **Illegal symbol.** Apply 01, 10, 11.
  - sym_err pulses on the second output; data_out = 1,0,1.
  - code_err = 0 throughout, because last_pol is still +1 when 11 arrives.
  - err_cnt = 1.
- **LOS (LOS_ZEROS = 32).** Apply 01, then 32 zeros, then 01.
  - los rises aligned with the 32nd zero and falls aligned with the trailing mark.
  - The trailing 01 raises no code_err, because pol_valid was cleared.
  - A run of 31 zeros never raises los.
- **Counter saturation (CNT_W = 4).** Force 20 violations.
  - err_cnt holds at 15.
  - clr_cnt asserted together with a violation gives err_cnt = 1.
  - clr_cnt alone gives err_cnt = 0.
- **Reset mid-stream.** Drive rst_n low for 1 cycle while los = 1 and err_cnt = 5.
  - After the edge: all outputs are 0.
  - A next 01 followed by 01 flags only the second mark.
